// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the video PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int RETRY_W = 4;

    // Counter width sized for the largest period; never narrower than 1 bit.
    function automatic int CNT_W(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises the video PLL: pulses its reset, qualifies LOCK, releases the video
// domain once lock is stable, and tracks timeout retries and a sticky fault.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic               video_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               fault,
    output logic [1:0]         dbg_state
);

    localparam int CW = CNT_W(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               fault_q, fault_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_rst_q, video_rst_q, ready_q;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk_i (clkin),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    assign retry_inc = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + 1'b1;

    // force_relock outranks every other exit, including lock loss in RUN.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        fault_d     = fault_q;
        lock_lost_d = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_d = RESET_PLL;
                end else if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = RESET_PLL;
                    retry_d = retry_inc;
                    fault_d = fault_q | (retry_inc >= RETRY_W'(MAX_RETRIES));
                end
            end
            STABILIZE: begin
                if (force_relock) begin
                    state_d = RESET_PLL;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (force_relock) begin
                    state_d = RESET_PLL;
                end else if (!locked_s) begin
                    state_d     = RESET_PLL;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    // The counter restarts on every state change and idles in RUN.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q) cnt_d = '0;
        else if (state_q == RUN) cnt_d = cnt_q;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            video_rst_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            fault_q     <= fault_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= (state_d == RESET_PLL);
            video_rst_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign video_rst = video_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
